imm_gen_stage: RTL and testbench
================================

Name: imm_gen_stage

Overview:
- Parametrised, registered successor to the combinational immediate chooser.
- Decodes the immediate for every RV32I/RV64I format directly from the raw instruction opcode: I, S, B, U, J, shift-amount and CSR-zimm.
- Also computes the PC-relative target (pc + imm) and the link address (pc + 4).
- Sits between fetch and decode behind a valid/ready FIFO so fetch and decode can stall independently.

Parameters:
- XLEN, 64, datapath width; legal values are 32 or 64.
- DEPTH, 2, entries in the output FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept an instruction
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes the head entry
- out_instr  out  32  raw instruction at head
- out_pc  out  XLEN  PC at head
- out_imm  out  XLEN  decoded immediate
- out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM
- out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN
- out_link  out  XLEN  out_pc + 4, modulo 2^XLEN
- out_illegal  out  1  opcode unsupported, or shamt illegal for XLEN

Behaviour:
- Reset (reset low, asynchronous): FIFO count = 0, pointers = 0, all storage cleared.
  - Outputs at reset: out_valid = 0, in_ready = 1, every out_* data field = 0.
  - Reset asserted mid-transfer discards all entries immediately.
- Enqueue occurs when in_valid && in_ready.
  - in_ready = (count < DEPTH), derived only from registered state; no combinational in→out path.
  - When full, in_ready = 0 even if out_ready = 1 in the same cycle.
- Dequeue occurs when out_valid && out_ready; out_valid = (count != 0).
- Latency: an instruction accepted at edge N is presented at the head after edge N, if the FIFO was empty.
- Ordering is strict FIFO. Simultaneous enqueue and dequeue leaves count unchanged; pointers wrap modulo DEPTH.
- Decode happens at enqueue time; the stored entry holds instr, pc, imm, fmt, target, link and illegal.
  - Sign extension is from instr[31] to XLEN.
  - LUI/AUIPC (U): {instr[31:12], 12'b0}, sign-extended.
  - JAL (J): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - BRANCH (B): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - STORE (S): {instr[31:25], instr[11:7]}.
  - LOAD, JALR, and non-shift OP-IMM / OP-IMM-32 (I): instr[31:20].
  - OP-IMM shifts (funct3 001/101) → SHAMT, zero-extended.
    - XLEN=64: shamt = instr[25:20].
    - XLEN=32: shamt = instr[24:20]; instr[25]=1 sets out_illegal.
  - OP-IMM-32 shifts → SHAMT = instr[24:20]. When XLEN=32, opcode OP-IMM-32 is illegal.
  - SYSTEM with funct3[2]=1 → ZIMM = instr[19:15], zero-extended.
  - SYSTEM with funct3[2]=0 → I.
  - OP, MISC-MEM and all other opcodes → fmt NONE, imm 0; out_illegal only for opcodes not listed in this section.
- Flush (synchronous, highest priority): count := 0.
  - The same-cycle in_valid is not accepted, even if in_ready was 1.
  - A same-cycle dequeue is harmless.
  - Next cycle: out_valid = 0, in_ready = 1.
- Held data is stable while out_valid && !out_ready.
- Data fields at the head are don't-care when out_valid = 0.

Test Plan:
- Reset release → out_valid=0, in_ready=1. Enqueue 0xFFF00093 (addi x1,x0,-1) at pc 0x80000000 → next cycle out_imm=0xFFFFFFFFFFFFFFFF, fmt=1, out_link=0x80000004.
- Back-to-back enqueue with out_ready=1:
  - 0x0020B423 (sd) → imm 8, fmt 2.
  - 0xFE000EE3 (beq) at pc 0x80000010 → imm −4, fmt 3, target 0x8000000C.
  - 0x001000EF (jal) at pc 0x80000000 → imm 0x800, fmt 5, target 0x80000800.
  - 0x800002B7 (lui) → imm 0xFFFFFFFF80000000, fmt 4.
  - Required: one result per cycle, in order.
- Shift-amount check: 0x03F09093 (slli x1,x1,63).
  - XLEN=64 → imm 63, fmt 6, illegal=0.
  - XLEN=32 → illegal=1.
- Backpressure: hold out_ready=0 and offer 3 instructions.
  - Required: in_ready=0 after DEPTH accepts, head stable.
  - Raise out_ready → entries drain in order, in_ready returns 1 the cycle after the first dequeue.
- Flush while full with in_valid=1 → next cycle out_valid=0 and the offered instruction is lost.
  - Then the FIFO accepts again with correct pointer wrap over 5 further entries.
- Assert reset mid-stream with 2 entries held → out_valid drops without a clock edge. After release, the first new instruction appears with no stale data.

Source files
------------

// File: rtl/imm_gen_stage_if.sv
// -----------------------------------------------------------------------------
// imm_gen_stage_if
// Handshake and data bundle between fetch, the immediate-generation stage and
// decode.
//   in_valid / in_ready / in_instr / in_pc      : fetch -> stage
//   out_valid / out_ready / out_*               : stage -> decode
// Modports:
//   slave  : the stage itself (consumes in_*, produces out_*)
//   master : the environment around the stage (fetch + decode side)
// -----------------------------------------------------------------------------
interface imm_gen_stage_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_target;
    logic [XLEN-1:0] out_link;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt,
               out_target, out_link, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt,
               out_target, out_link, out_illegal
    );
endinterface

// File: rtl/imm_gen_stage.sv
// -----------------------------------------------------------------------------
// imm_gen_stage
// Registered immediate generator between fetch and decode. Each accepted
// instruction is decoded on entry (immediate, format, PC-relative target,
// link address, illegal flag) and parked in a DEPTH-entry FIFO so that fetch
// and decode can stall independently.
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-low reset; empties the FIFO, clears storage
//   flush  : synchronous squash of all held entries; wins over enqueue
//   bus    : imm_gen_stage_if.slave (in_* from fetch, out_* to decode)
// out_fmt encoding: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
// -----------------------------------------------------------------------------
module imm_gen_stage #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    imm_gen_stage_if.slave   bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0]   PTR_ONE   = PW'(1'b1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0]   CNT_FULL  = CW'(DEPTH);
    localparam logic [XLEN-1:0] LINK_STEP = XLEN'(3'd4);

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ZIMM  = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } dec_t;

    // Widen a 32-bit value to XLEN by replicating bit 31.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    // Opcode-driven immediate decode; every format is assembled as a full
    // 32-bit pattern first so one sign-extension helper serves them all.
    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [2:0] funct3;
        logic       is_shift;
        funct3    = instr[14:12];
        is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);
        d.imm     = '0;
        d.fmt     = FMT_NONE;
        d.illegal = 1'b0;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC: begin
                d.imm = sext32({instr[31:12], 12'b0});
                d.fmt = FMT_U;
            end
            OPC_JAL: begin
                d.imm = sext32({{11{instr[31]}}, instr[31], instr[19:12],
                                instr[20], instr[30:21], 1'b0});
                d.fmt = FMT_J;
            end
            OPC_BRANCH: begin
                d.imm = sext32({{19{instr[31]}}, instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0});
                d.fmt = FMT_B;
            end
            OPC_STORE: begin
                d.imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
                d.fmt = FMT_S;
            end
            OPC_LOAD, OPC_JALR: begin
                d.imm = sext32({{20{instr[31]}}, instr[31:20]});
                d.fmt = FMT_I;
            end
            OPC_OP_IMM: begin
                if (is_shift) begin
                    d.fmt = FMT_SHAMT;
                    if (XLEN == 64) begin
                        d.imm[5:0] = instr[25:20];
                    end else begin
                        // A 6-bit shift amount cannot be honoured on RV32.
                        d.imm[4:0] = instr[24:20];
                        d.illegal  = instr[25];
                    end
                end else begin
                    d.imm = sext32({{20{instr[31]}}, instr[31:20]});
                    d.fmt = FMT_I;
                end
            end
            OPC_OP_IMM_32: begin
                d.illegal = (XLEN == 32);
                if (is_shift) begin
                    d.imm[4:0] = instr[24:20];
                    d.fmt      = FMT_SHAMT;
                end else begin
                    d.imm = sext32({{20{instr[31]}}, instr[31:20]});
                    d.fmt = FMT_I;
                end
            end
            OPC_SYSTEM: begin
                if (funct3[2]) begin
                    d.imm[4:0] = instr[19:15];
                    d.fmt      = FMT_ZIMM;
                end else begin
                    d.imm = sext32({{20{instr[31]}}, instr[31:20]});
                    d.fmt = FMT_I;
                end
            end
            OPC_OP, OPC_MISC_MEM: begin
                d.fmt = FMT_NONE;
            end
            default: begin
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

    logic [31:0]     instr_mem_r   [DEPTH];
    logic [XLEN-1:0] pc_mem_r      [DEPTH];
    logic [XLEN-1:0] imm_mem_r     [DEPTH];
    logic [XLEN-1:0] target_mem_r  [DEPTH];
    logic [XLEN-1:0] link_mem_r    [DEPTH];
    logic [2:0]      fmt_mem_r     [DEPTH];
    logic            illegal_mem_r [DEPTH];

    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            in_ready_r;
    logic            out_valid_r;

    dec_t            dec_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] link_s;
    logic            enq_s;
    logic            deq_s;
    logic [CW-1:0]   count_nxt_s;

    assign dec_s    = decode(bus.in_instr);
    assign target_s = bus.in_pc + dec_s.imm;
    assign link_s   = bus.in_pc + LINK_STEP;

    // Handshakes only look at registered flags, so no input reaches an output
    // combinationally.
    assign enq_s = bus.in_valid && in_ready_r;
    assign deq_s = out_valid_r && bus.out_ready;

    // Occupancy after this edge, ignoring flush (handled in the register block).
    always_comb begin
        count_nxt_s = count_r;
        if (enq_s && !deq_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (!enq_s && deq_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO storage, pointers and registered handshake flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_r[i]   <= '0;
                pc_mem_r[i]      <= '0;
                imm_mem_r[i]     <= '0;
                target_mem_r[i]  <= '0;
                link_mem_r[i]    <= '0;
                fmt_mem_r[i]     <= '0;
                illegal_mem_r[i] <= 1'b0;
            end
        end else if (flush) begin
            // Squash: the offered instruction is dropped as well.
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            if (enq_s) begin
                instr_mem_r[wr_ptr_r]   <= bus.in_instr;
                pc_mem_r[wr_ptr_r]      <= bus.in_pc;
                imm_mem_r[wr_ptr_r]     <= dec_s.imm;
                target_mem_r[wr_ptr_r]  <= target_s;
                link_mem_r[wr_ptr_r]    <= link_s;
                fmt_mem_r[wr_ptr_r]     <= dec_s.fmt;
                illegal_mem_r[wr_ptr_r] <= dec_s.illegal;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r     <= count_nxt_s;
            in_ready_r  <= (count_nxt_s < CNT_FULL);
            out_valid_r <= (count_nxt_s != '0);
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_instr   = instr_mem_r[rd_ptr_r];
    assign bus.out_pc      = pc_mem_r[rd_ptr_r];
    assign bus.out_imm     = imm_mem_r[rd_ptr_r];
    assign bus.out_fmt     = fmt_mem_r[rd_ptr_r];
    assign bus.out_target  = target_mem_r[rd_ptr_r];
    assign bus.out_link    = link_mem_r[rd_ptr_r];
    assign bus.out_illegal = illegal_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_imm_gen_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_stage
// Drives an XLEN=64 and an XLEN=32 instance with identical stimulus. Expected
// results come from directed constants and from an arithmetic reference
// decoder feeding per-instance expectation queues.
// -----------------------------------------------------------------------------
module tb_imm_gen_stage;
    localparam int DEPTH = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(64)) bus64 ();
    imm_gen_stage_if #(.XLEN(32)) bus32 ();

    imm_gen_stage #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus64.slave));
    imm_gen_stage #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus32.slave));

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] target;
        logic [63:0] link;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t q64[$];
    exp_t q32[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic        cur_v, cur_rdy, cur_fl;
    logic [31:0] cur_ins;
    logic [63:0] cur_pc;

    // Reference decoder: immediates built with signed integer arithmetic.
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [63:0] pc,
                                       input int xlen);
        exp_t        e;
        longint      s;
        logic [63:0] mask;
        logic [2:0]  f3;
        mask  = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        s     = longint'($signed(ins));
        f3    = ins[14:12];
        e.instr = ins;
        e.imm = 64'd0;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        case (ins[6:0])
            7'h37, 7'h17: begin
                e.imm = 64'(s) & 64'hFFFF_FFFF_FFFF_F000; e.fmt = 3'd4;
            end
            7'h6F: begin
                e.imm = 64'(((s < 0) ? -64'sd1048576 : 64'sd0)
                        + longint'(ins[19:12]) * 64'sd4096
                        + longint'(ins[20]) * 64'sd2048
                        + longint'(ins[30:21]) * 64'sd2);
                e.fmt = 3'd5;
            end
            7'h63: begin
                e.imm = 64'(((s < 0) ? -64'sd4096 : 64'sd0)
                        + longint'(ins[7]) * 64'sd2048
                        + longint'(ins[30:25]) * 64'sd32
                        + longint'(ins[11:8]) * 64'sd2);
                e.fmt = 3'd3;
            end
            7'h23: begin
                e.imm = 64'((s >>> 25) * 64'sd32 + longint'(ins[11:7])); e.fmt = 3'd2;
            end
            7'h03, 7'h67: begin
                e.imm = 64'(s >>> 20); e.fmt = 3'd1;
            end
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.fmt = 3'd6;
                    if (xlen == 64) e.imm = 64'(ins[25:20]);
                    else begin e.imm = 64'(ins[24:20]); e.ill = ins[25]; end
                end else begin
                    e.imm = 64'(s >>> 20); e.fmt = 3'd1;
                end
            end
            7'h1B: begin
                e.ill = (xlen == 32);
                if (f3 == 3'd1 || f3 == 3'd5) begin e.imm = 64'(ins[24:20]); e.fmt = 3'd6; end
                else begin e.imm = 64'(s >>> 20); e.fmt = 3'd1; end
            end
            7'h73: begin
                if (f3 >= 3'd4) begin e.imm = 64'(ins[19:15]); e.fmt = 3'd7; end
                else begin e.imm = 64'(s >>> 20); e.fmt = 3'd1; end
            end
            7'h33, 7'h0F: e.fmt = 3'd0;
            default: e.ill = 1'b1;
        endcase
        e.imm    = e.imm & mask;
        e.pc     = pc & mask;
        e.target = (e.pc + e.imm) & mask;
        e.link   = (e.pc + 64'd4) & mask;
        return e;
    endfunction

    // Apply inputs (called just after a rising edge) and move to the falling edge.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                         input logic rdy, input logic fl);
        cur_v = v; cur_ins = ins; cur_pc = pc; cur_rdy = rdy; cur_fl = fl;
        bus64.in_valid = v; bus64.in_instr = ins; bus64.in_pc = pc;       bus64.out_ready = rdy;
        bus32.in_valid = v; bus32.in_instr = ins; bus32.in_pc = pc[31:0]; bus32.out_ready = rdy;
        flush = fl;
        @(negedge clk);
    endtask

    // Take the rising edge and update the expectation queues.
    task automatic advance();
        logic enq, deq;
        enq = cur_v && !cur_fl && (q64.size() < DEPTH);
        deq = cur_rdy && (q64.size() != 0);
        @(posedge clk);
        #1;
        if (cur_fl) begin
            q64.delete(); q32.delete();
        end else begin
            if (deq) begin void'(q64.pop_front()); void'(q32.pop_front()); end
            if (enq) begin
                q64.push_back(ref_model(cur_ins, cur_pc, 64));
                q32.push_back(ref_model(cur_ins, cur_pc, 32));
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
        n_tests++;
        if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_hs64: got v=%b r=%b expected v=0 r=1", bus64.out_valid, bus64.in_ready);
        end
        n_tests++;
        if (bus64.out_imm !== 64'd0 || bus64.out_instr !== 32'd0 || bus64.out_pc !== 64'd0 ||
            bus64.out_target !== 64'd0 || bus64.out_link !== 64'd0 || bus64.out_fmt !== 3'd0 ||
            bus64.out_illegal !== 1'b0) begin
            n_fail++; $display("FAIL reset_data64: got imm=%h link=%h expected all zero", bus64.out_imm, bus64.out_link);
        end
        n_tests++;
        if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || bus32.out_imm !== 32'd0) begin
            n_fail++; $display("FAIL reset_32: got v=%b r=%b imm=%h expected 0/1/0", bus32.out_valid, bus32.in_ready, bus32.out_imm);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
        n_tests++;
        if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release: got v=%b r=%b expected v=0 r=1", bus64.out_valid, bus64.in_ready);
        end
        advance();
    endtask

    task automatic test_addi();
        drive(1'b1, 32'hFFF00093, 64'h8000_0000, 1'b1, 1'b0);
        advance();
        drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        n_tests++;
        if (bus64.out_valid !== 1'b1 || bus64.out_imm !== 64'hFFFF_FFFF_FFFF_FFFF ||
            bus64.out_fmt !== 3'd1 || bus64.out_link !== 64'h8000_0004) begin
            n_fail++; $display("FAIL addi64: got v=%b imm=%h fmt=%0d link=%h expected 1/ffffffffffffffff/1/80000004",
                               bus64.out_valid, bus64.out_imm, bus64.out_fmt, bus64.out_link);
        end
        n_tests++;
        if (bus32.out_imm !== 32'hFFFF_FFFF || bus32.out_link !== 32'h8000_0004 || bus32.out_illegal !== 1'b0) begin
            n_fail++; $display("FAIL addi32: got imm=%h link=%h ill=%b expected ffffffff/80000004/0",
                               bus32.out_imm, bus32.out_link, bus32.out_illegal);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [4];
        logic [63:0] pcs [4];
        logic [63:0] imm [4];
        logic [63:0] tgt [4];
        logic [2:0]  fmt [4];
        ins = '{32'h0020B423, 32'hFE000EE3, 32'h001000EF, 32'h800002B7};
        pcs = '{64'h8000_0004, 64'h8000_0010, 64'h8000_0000, 64'h8000_0020};
        imm = '{64'd8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h800, 64'hFFFF_FFFF_8000_0000};
        tgt = '{64'h8000_000C, 64'h8000_000C, 64'h8000_0800, 64'h20};
        fmt = '{3'd2, 3'd3, 3'd5, 3'd4};
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) drive(1'b1, ins[k], pcs[k], 1'b1, 1'b0);
            else       drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
            if (k > 0) begin
                n_tests++;
                if (bus64.out_valid !== 1'b1 || bus64.out_instr !== ins[k-1] || bus64.out_imm !== imm[k-1] ||
                    bus64.out_fmt !== fmt[k-1] || bus64.out_target !== tgt[k-1]) begin
                    n_fail++; $display("FAIL b2b_%0d: got v=%b instr=%h imm=%h fmt=%0d tgt=%h expected instr=%h imm=%h fmt=%0d tgt=%h",
                                       k - 1, bus64.out_valid, bus64.out_instr, bus64.out_imm, bus64.out_fmt,
                                       bus64.out_target, ins[k-1], imm[k-1], fmt[k-1], tgt[k-1]);
                end
            end
            advance();
        end
    endtask

    task automatic test_shamt();
        drive(1'b1, 32'h03F09093, 64'h1000, 1'b1, 1'b0);
        advance();
        drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        n_tests++;
        if (bus64.out_imm !== 64'd63 || bus64.out_fmt !== 3'd6 || bus64.out_illegal !== 1'b0) begin
            n_fail++; $display("FAIL shamt64: got imm=%0d fmt=%0d ill=%b expected 63/6/0",
                               bus64.out_imm, bus64.out_fmt, bus64.out_illegal);
        end
        n_tests++;
        if (bus32.out_illegal !== 1'b1 || bus32.out_fmt !== 3'd6 || bus32.out_imm !== 32'd31) begin
            n_fail++; $display("FAIL shamt32: got imm=%0d fmt=%0d ill=%b expected 31/6/1",
                               bus32.out_imm, bus32.out_fmt, bus32.out_illegal);
        end
        advance();
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, c;
        logic [31:0] exp_head [7];
        logic        exp_rdy  [7];
        logic        vld [7];
        logic        ordy [7];
        a = 32'h00100093; b = 32'h00200093; c = 32'h00300093;
        exp_head = '{32'd0, a, a, a, b, c, 32'd0};
        exp_rdy  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vld      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        ordy     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 7; k++) begin
            drive(vld[k], (k == 0) ? a : (k == 1) ? b : c, 64'h2000 + 64'(k), ordy[k], 1'b0);
            n_tests++;
            if (bus64.in_ready !== exp_rdy[k]) begin
                n_fail++; $display("FAIL bp_ready_%0d: got %b expected %b", k, bus64.in_ready, exp_rdy[k]);
            end
            if (k >= 1 && k <= 5) begin
                n_tests++;
                if (bus64.out_valid !== 1'b1 || bus64.out_instr !== exp_head[k]) begin
                    n_fail++; $display("FAIL bp_head_%0d: got v=%b instr=%h expected 1/%h",
                                       k, bus64.out_valid, bus64.out_instr, exp_head[k]);
                end
            end
            advance();
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h00500013, 64'h3000, 1'b0, 1'b0); advance();
        drive(1'b1, 32'h00600013, 64'h3004, 1'b0, 1'b0); advance();
        drive(1'b1, 32'h00700013, 64'h3008, 1'b1, 1'b1); advance();
        drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
        n_tests++;
        if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush: got v=%b r=%b expected v=0 r=1", bus64.out_valid, bus64.in_ready);
        end
        advance();
        for (int k = 0; k <= 5; k++) begin
            if (k < 5) drive(1'b1, 32'h00000013 | (32'(k + 1) << 20), 64'h4000 + 64'(4 * k), 1'b1, 1'b0);
            else       drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
            if (k > 0) begin
                n_tests++;
                if (bus64.out_valid !== 1'b1 || bus64.out_imm !== 64'(k) || bus64.out_pc !== 64'h4000 + 64'(4 * (k - 1))) begin
                    n_fail++; $display("FAIL wrap_%0d: got v=%b imm=%h pc=%h expected 1/%h/%h", k - 1,
                                       bus64.out_valid, bus64.out_imm, bus64.out_pc, 64'(k), 64'h4000 + 64'(4 * (k - 1)));
                end
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h0FF00093, 64'h5000, 1'b0, 1'b0); advance();
        drive(1'b1, 32'h0EE00093, 64'h5004, 1'b0, 1'b0); advance();
        bus64.in_valid = 1'b0; bus32.in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1 || bus64.out_imm !== 64'd0 ||
            bus32.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got v=%b r=%b imm=%h expected 0/1/0",
                               bus64.out_valid, bus64.in_ready, bus64.out_imm);
        end
        q64.delete(); q32.delete();
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 32'h12345037, 64'h6000, 1'b1, 1'b0); advance();
        drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        n_tests++;
        if (bus64.out_valid !== 1'b1 || bus64.out_instr !== 32'h12345037 ||
            bus64.out_imm !== 64'h1234_5000 || bus64.out_fmt !== 3'd4) begin
            n_fail++; $display("FAIL post_reset: got v=%b instr=%h imm=%h expected 1/12345037/12345000",
                               bus64.out_valid, bus64.out_instr, bus64.out_imm);
        end
        advance();
    endtask

    task automatic test_random();
        logic [6:0]  ops [12];
        logic [31:0] ins;
        int          pick;
        ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
        for (int k = 0; k < 400; k++) begin
            ins  = $urandom;
            pick = $urandom_range(0, 13);
            if (pick < 12) ins[6:0] = ops[pick];
            drive(1'($urandom_range(0, 3) != 0), ins, {32'($urandom), 32'($urandom)},
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
            n_tests++;
            if (bus64.in_ready !== (q64.size() < DEPTH) || bus64.out_valid !== (q64.size() != 0) ||
                bus32.in_ready !== (q32.size() < DEPTH) || bus32.out_valid !== (q32.size() != 0)) begin
                n_fail++; $display("FAIL rand_hs_%0d: got r=%b v=%b expected r=%b v=%b", k,
                                   bus64.in_ready, bus64.out_valid, q64.size() < DEPTH, q64.size() != 0);
            end
            if (q64.size() != 0) begin
                n_tests++;
                if (bus64.out_instr !== q64[0].instr || bus64.out_pc !== q64[0].pc || bus64.out_imm !== q64[0].imm ||
                    bus64.out_fmt !== q64[0].fmt || bus64.out_target !== q64[0].target ||
                    bus64.out_link !== q64[0].link || bus64.out_illegal !== q64[0].ill) begin
                    n_fail++; $display("FAIL rand64_%0d: got instr=%h imm=%h fmt=%0d tgt=%h ill=%b expected instr=%h imm=%h fmt=%0d tgt=%h ill=%b",
                                       k, bus64.out_instr, bus64.out_imm, bus64.out_fmt, bus64.out_target, bus64.out_illegal,
                                       q64[0].instr, q64[0].imm, q64[0].fmt, q64[0].target, q64[0].ill);
                end
                n_tests++;
                if (64'(bus32.out_pc) !== q32[0].pc || 64'(bus32.out_imm) !== q32[0].imm ||
                    bus32.out_fmt !== q32[0].fmt || 64'(bus32.out_target) !== q32[0].target ||
                    64'(bus32.out_link) !== q32[0].link || bus32.out_illegal !== q32[0].ill) begin
                    n_fail++; $display("FAIL rand32_%0d: got instr=%h imm=%h fmt=%0d tgt=%h ill=%b expected imm=%h fmt=%0d tgt=%h ill=%b",
                                       k, bus32.out_instr, bus32.out_imm, bus32.out_fmt, bus32.out_target, bus32.out_illegal,
                                       q32[0].imm, q32[0].fmt, q32[0].target, q32[0].ill);
                end
            end
            advance();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_shamt();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
